// File: rtl/ervp_apb_two_master_arbiter.sv
// Round-robin arbiter sharing one APB completer between two APB requesters.
// Optional ACCESS-phase timeout is enabled by defining ERVP_APB_ARBITER_TIMEOUT_EN.
module ervp_apb_two_master_arbiter #(
    parameter int BW_ADDR        = 32,
    parameter int BW_DATA        = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               rp0psel,
    input  logic               rp0penable,
    input  logic [BW_ADDR-1:0] rp0paddr,
    input  logic               rp0pwrite,
    input  logic [BW_DATA-1:0] rp0pwdata,
    output logic [BW_DATA-1:0] rp0prdata,
    output logic               rp0pready,
    output logic               rp0pslverr,
    input  logic               rp1psel,
    input  logic               rp1penable,
    input  logic [BW_ADDR-1:0] rp1paddr,
    input  logic               rp1pwrite,
    input  logic [BW_DATA-1:0] rp1pwdata,
    output logic [BW_DATA-1:0] rp1prdata,
    output logic               rp1pready,
    output logic               rp1pslverr,
    output logic               sppsel,
    output logic               sppenable,
    output logic [BW_ADDR-1:0] sppaddr,
    output logic               sppwrite,
    output logic [BW_DATA-1:0] sppwdata,
    input  logic [BW_DATA-1:0] spprdata,
    input  logic               sppready,
    input  logic               sppslverr,
    output logic               grant_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q;
    logic   grant_q;
    logic   last_q;
    logic   grant_d;
    logic   in_setup;
    logic   in_access;
    logic   done;
    logic   resp_err;
    logic   timeout_hit;
    logic   unused_cfg;

    // Requester penable is implied by our own SETUP/ACCESS sequencing.
    assign unused_cfg = rp0penable ^ rp1penable ^ (TIMEOUT_CYCLES != 0);

    always_comb begin
        grant_d = 1'b0;
        if (rp0psel && rp1psel) begin
            grant_d = ~last_q;
        end else if (rp1psel) begin
            grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstnn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rp0psel || rp1psel) begin
                        state_q <= ST_SETUP;
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                    end
                end
                ST_SETUP:  state_q <= ST_ACCESS;
                ST_ACCESS: begin
                    if (sppready || timeout_hit) begin
                        state_q <= ST_IDLE;
                    end
                end
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ERVP_APB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Cleared while in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rstnn) begin
            cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !sppready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && !sppready &&
                         (state_q == ST_ACCESS) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Reset gates the bus outputs immediately, abandoning any transfer in flight.
    assign in_setup  = !rstnn && (state_q == ST_SETUP);
    assign in_access = !rstnn && (state_q == ST_ACCESS);
    assign done      = in_access && (sppready || timeout_hit);
    assign resp_err  = sppready ? sppslverr : 1'b1;

    assign sppsel    = in_setup || in_access;
    assign sppenable = in_access;
    assign busy      = !rstnn && (state_q != ST_IDLE);
    assign grant_id  = grant_q;

    assign sppaddr   = grant_q ? rp1paddr  : rp0paddr;
    assign sppwrite  = grant_q ? rp1pwrite : rp0pwrite;
    assign sppwdata  = grant_q ? rp1pwdata : rp0pwdata;

    assign rp0prdata  = spprdata;
    assign rp1prdata  = spprdata;
    assign rp0pready  = done && !grant_q;
    assign rp1pready  = done &&  grant_q;
    assign rp0pslverr = rp0pready && resp_err;
    assign rp1pslverr = rp1pready && resp_err;

endmodule

// File: doc/ervp_apb_two_master_arbiter.md
Name: ervp_apb_two_master_arbiter

Overview:
- Shares one APB completer between two APB requesters (port 0, port 1).
- Sits between two bus masters (e.g. a core-side bridge and a DMA) and a single APB slave, such as a peripheral or a dummy error slave.
- Round-robin grant; re-issues the granted transfer downstream with proper SETUP/ACCESS phasing and returns the response to the granted requester only.
- Optional access timeout converts a hung slave into an error response.

Parameters:
- BW_ADDR, 32, address width on all ports
- BW_DATA, 32, data width on all ports
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with the optional feature; 0 = never time out

Ports:
- clk  input  1  clock
- rstnn  input  1  reset; synchronous, active-high (1 = reset)
- rp0psel / rp1psel  input  1  requester select
- rp0penable / rp1penable  input  1  requester enable
- rp0paddr / rp1paddr  input  BW_ADDR  requester address
- rp0pwrite / rp1pwrite  input  1  requester write flag
- rp0pwdata / rp1pwdata  input  BW_DATA  requester write data
- rp0prdata / rp1prdata  output  BW_DATA  read data to requester
- rp0pready / rp1pready  output  1  completion to requester
- rp0pslverr / rp1pslverr  output  1  error to requester
- sppsel  output  1  downstream select
- sppenable  output  1  downstream enable
- sppaddr  output  BW_ADDR  downstream address
- sppwrite  output  1  downstream write flag
- sppwdata  output  BW_DATA  downstream write data
- spprdata  input  BW_DATA  downstream read data
- sppready  input  1  downstream ready
- sppslverr  input  1  downstream error
- grant_id  output  1  index of the currently/last granted requester
- busy  output  1  1 when state is not IDLE

Behaviour:
- State machine: IDLE, SETUP, ACCESS. All state is registered and updates on the clk rising edge.
- Reset (rstnn=1): state=IDLE, grant_id=0, last-grant pointer=1 (requester 0 wins first), timeout counter=0.
- Outputs while in reset or IDLE: sppsel=0, sppenable=0, all rp*pready=0, all rp*pslverr=0, busy=0.
- IDLE arbitration:
  - A requester is pending when its rpNpsel=1.
  - Only one pending: grant it.
  - Both pending: grant the requester not equal to the last-grant pointer.
  - On grant, next state=SETUP and grant_id/pointer update to the winner.
  - No request: stay in IDLE.
- SETUP: sppsel=1, sppenable=0; next state=ACCESS unconditionally.
- ACCESS: sppsel=1, sppenable=1.
  - If sppready=1: rpGpready=1 and rpGpslverr=sppslverr (combinational, same cycle; G = granted requester); next state=IDLE.
  - Otherwise stay in ACCESS.
- sppaddr/sppwrite/sppwdata: combinational mux of the granted requester's signals. The requester holds them stable per APB. Value is don't-care in IDLE; the mux still selects grant_id.
- rp0prdata = rp1prdata = spprdata (valid only with the matching pready).
- Non-granted requester: pready=0, pslverr=0 at all times.
- Minimum latency, requester psel at cycle 0 with a zero-wait slave: SETUP in cycle 1, ACCESS plus rpready in cycle 2, IDLE in cycle 3. Back-to-back from the same requester gives one transfer per 3 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Requester drops psel after grant (protocol violation): downstream transfer still completes. The pready pulse is driven regardless; the requester ignores it.
- Reset asserted mid-SETUP/ACCESS: next cycle is IDLE with all outputs at reset values. The downstream transfer is abandoned.

Optional Feature:
- Macro: ERVP_APB_ARBITER_TIMEOUT_EN.
- With the macro:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with sppready=0.
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0) and sppready=0: rpGpready=1, rpGpslverr=1, next state=IDLE. Downstream psel/penable drop the following cycle.
  - sppready=1 in the same cycle as the limit takes precedence and passes the normal response.
- Without the macro: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is ignored.

Test Plan:
- Req0 reads 0x10, slave ready at once with prdata=0xA5A5A5A5 -> sppsel in cycles 1-2, sppenable in cycle 2, rp0pready=1 in cycle 2 with rp0prdata=0xA5A5A5A5, rp1pready stays 0.
- Both requesters assert psel in the same cycle right after reset -> grant order 0,1,0,1 over four transfers; grant_id matches each time.
- Req1 write 0x20=0x1234, slave inserts 3 wait states -> ACCESS lasts 4 cycles, sppwdata=0x1234 throughout, a single rp1pready pulse on the 4th.
- Slave returns sppslverr=1 with sppready=1 -> rp0pslverr=1 for exactly that cycle, then IDLE, busy=0.
- Macro defined, TIMEOUT_CYCLES=8, slave never ready -> rpGpready=1 and rpGpslverr=1 after 8 ACCESS cycles, then sppsel=0 the next cycle. Macro undefined -> busy stays 1 for 100 cycles.
- rstnn=1 pulsed during ACCESS -> next cycle sppsel=0, sppenable=0, busy=0, grant_id=0; the next simultaneous request grants requester 0.
